// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU datapath between the instruction-issue
// path (requester 0) and an auxiliary engine (requester 1).
// Each operation walks IDLE -> EXEC -> CAPT -> RESP. EXEC gives the ALU a full
// cycle to settle before CAPT registers its output.
// Optional feature macro: ALU_ARB_RR_EN selects round-robin arbitration.
// Without it, requester 0 has fixed priority.
module alu_share_arbiter #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ0_VALID,
  input  logic             REQ1_VALID,
  output logic             REQ0_READY,
  output logic             REQ1_READY,
  input  logic [SEL_W-1:0] REQ0_SEL,
  input  logic [SEL_W-1:0] REQ1_SEL,
  input  logic [WIDTH-1:0] REQ0_DATA1,
  input  logic [WIDTH-1:0] REQ0_DATA2,
  input  logic [WIDTH-1:0] REQ1_DATA1,
  input  logic [WIDTH-1:0] REQ1_DATA2,
  output logic             RSP0_VALID,
  output logic             RSP1_VALID,
  input  logic             RSP0_READY,
  input  logic             RSP1_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] ALU_DATA1,
  output logic [WIDTH-1:0] ALU_DATA2,
  output logic [SEL_W-1:0] ALU_SELECT,
  input  logic [WIDTH-1:0] ALU_RESULT,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               grant_q, grant_d;
  logic [WIDTH-1:0]   aluData1_q, aluData1_d;
  logic [WIDTH-1:0]   aluData2_q, aluData2_d;
  logic [SEL_W-1:0]   aluSel_q, aluSel_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               win0, win1;
`ifdef ALU_ARB_RR_EN
  // prio_q high means requester 1 wins the next tie.
  logic               prio_q, prio_d;
`endif

  // Pick this cycle's winner. A grant is only possible while idle.
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    if (state_q == IDLE) begin
`ifdef ALU_ARB_RR_EN
      if (REQ0_VALID && REQ1_VALID) begin
        win0 = ~prio_q;
        win1 = prio_q;
      end else begin
        win0 = REQ0_VALID;
        win1 = REQ1_VALID;
      end
`else
      win0 = REQ0_VALID;
      win1 = REQ1_VALID && !REQ0_VALID;
`endif
    end
  end

  // READY is gated by reset so that no handshake completes while reset is asserted.
  assign REQ0_READY = RESET & win0;
  assign REQ1_READY = RESET & win1;
  assign RSP0_VALID = (state_q == RESP) && !grant_q;
  assign RSP1_VALID = (state_q == RESP) && grant_q;
  assign BUSY       = (state_q != IDLE);
  assign RESULT     = result_q;
  assign ALU_DATA1  = aluData1_q;
  assign ALU_DATA2  = aluData2_q;
  assign ALU_SELECT = aluSel_q;

  // Next-state and datapath loads. Registers hold unless a state explicitly updates them.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    aluData1_d = aluData1_q;
    aluData2_d = aluData2_q;
    aluSel_d   = aluSel_q;
    result_d   = result_q;
`ifdef ALU_ARB_RR_EN
    prio_d     = prio_q;
`endif
    case (state_q)
      IDLE: begin
        if (win0 || win1) begin
          state_d = EXEC;
          grant_d = win1;
`ifdef ALU_ARB_RR_EN
          prio_d  = win0;
`endif
          if (win1) begin
            aluData1_d = REQ1_DATA1;
            aluData2_d = REQ1_DATA2;
            aluSel_d   = REQ1_SEL;
          end else begin
            aluData1_d = REQ0_DATA1;
            aluData2_d = REQ0_DATA2;
            aluSel_d   = REQ0_SEL;
          end
        end
      end
      EXEC: state_d = CAPT;
      CAPT: begin
        result_d = ALU_RESULT;
        state_d  = RESP;
      end
      RESP: begin
        if (grant_q ? RSP1_READY : RSP0_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset drops any in-flight operation.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      aluData1_q <= '0;
      aluData2_q <= '0;
      aluSel_q   <= '0;
      result_q   <= '0;
`ifdef ALU_ARB_RR_EN
      prio_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      aluData1_q <= aluData1_d;
      aluData2_q <= aluData2_d;
      aluSel_q   <= aluSel_d;
      result_q   <= result_d;
`ifdef ALU_ARB_RR_EN
      prio_q     <= prio_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed-vector bench for alu_share_arbiter.
// It includes a behavioural ALU model with the encoding
// AND=001, ADD=010, OR=011, MOV=100.
module tb_alu_share_arbiter;

  logic       clk = 1'b0;
  logic       rstN;
  logic       req0Valid, req1Valid, req0Ready, req1Ready;
  logic [2:0] req0Sel, req1Sel;
  logic [7:0] req0Data1, req0Data2, req1Data1, req1Data2;
  logic       rsp0Valid, rsp1Valid, rsp0Ready, rsp1Ready;
  logic [7:0] result, aluData1, aluData2, aluResult;
  logic [2:0] aluSelect;
  logic       busy;
  int         compareCount = 0;
  int         failCount = 0;

  alu_share_arbiter #(.WIDTH(8), .SEL_W(3)) dut (
    .CLK(clk), .RESET(rstN),
    .REQ0_VALID(req0Valid), .REQ1_VALID(req1Valid),
    .REQ0_READY(req0Ready), .REQ1_READY(req1Ready),
    .REQ0_SEL(req0Sel), .REQ1_SEL(req1Sel),
    .REQ0_DATA1(req0Data1), .REQ0_DATA2(req0Data2),
    .REQ1_DATA1(req1Data1), .REQ1_DATA2(req1Data2),
    .RSP0_VALID(rsp0Valid), .RSP1_VALID(rsp1Valid),
    .RSP0_READY(rsp0Ready), .RSP1_READY(rsp1Ready),
    .RESULT(result), .ALU_DATA1(aluData1), .ALU_DATA2(aluData2),
    .ALU_SELECT(aluSelect), .ALU_RESULT(aluResult), .BUSY(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU standing in for the real datapath.
  always_comb begin
    case (aluSelect)
      3'b001:  aluResult = aluData1 & aluData2;
      3'b010:  aluResult = aluData1 + aluData2;
      3'b011:  aluResult = aluData1 | aluData2;
      3'b100:  aluResult = aluData1;
      default: aluResult = 8'h00;
    endcase
  end

  // Counts one comparison and reports it when the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drives one requester's request channel.
  task automatic applyStimulus(input int idx, input logic v, input logic [2:0] s,
                               input logic [7:0] d1, input logic [7:0] d2);
    if (idx == 0) begin
      req0Valid = v; req0Sel = s; req0Data1 = d1; req0Data2 = d2;
    end else begin
      req1Valid = v; req1Sel = s; req1Data1 = d1; req1Data2 = d2;
    end
  endtask

  // Moves to the next falling edge, which keeps sampling away from the active edge.
  task automatic nextNeg();
    @(negedge clk);
  endtask

  // Stops the run if it runs far past the expected length.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic expG;
    rstN = 1'b0;
    rsp0Ready = 1'b0; rsp1Ready = 1'b0;
    applyStimulus(0, 1'b1, 3'b011, 8'hA5, 8'h0F);
    applyStimulus(1, 1'b0, 3'b000, 8'h00, 8'h00);
    #12;
    checkOutput("rst_ready0", req0Ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_alu", {aluData1, aluData2, aluSelect}, 0);
    checkOutput("rst_rsp", {rsp0Valid, rsp1Valid}, 0);
    nextNeg();
    applyStimulus(0, 1'b0, 3'b011, 8'hA5, 8'h0F);
    rstN = 1'b1;

    // Single OR request from requester 0.
    nextNeg();
    applyStimulus(0, 1'b1, 3'b011, 8'hA5, 8'h0F);
    #1;
    checkOutput("t1_ready0", req0Ready, 1);
    checkOutput("t1_ready1", req1Ready, 0);
    nextNeg();
    checkOutput("t1_exec_ready0", req0Ready, 0);
    checkOutput("t1_exec_busy", busy, 1);
    checkOutput("t1_alu_ops", {aluData1, aluData2, aluSelect}, {8'hA5, 8'h0F, 3'b011});
    checkOutput("t1_exec_rsp0", rsp0Valid, 0);
    applyStimulus(0, 1'b0, 3'b011, 8'h33, 8'h0F);
    nextNeg();
    checkOutput("t1_capt_rsp0", rsp0Valid, 0);
    checkOutput("t1_stable_d1", aluData1, 8'hA5);
    nextNeg();
    checkOutput("t1_rsp0", rsp0Valid, 1);
    checkOutput("t1_rsp1", rsp1Valid, 0);
    checkOutput("t1_result", result, 8'hAF);
    rsp0Ready = 1'b1;
    nextNeg();
    checkOutput("t1_done_busy", busy, 0);
    checkOutput("t1_done_rsp0", rsp0Valid, 0);
    checkOutput("t1_hold_d1", aluData1, 8'hA5);

    // Reset again so the round-robin pointer starts at requester 0, then hold both requests.
    rstN = 1'b0;
    nextNeg();
    rstN = 1'b1;
    rsp1Ready = 1'b1;
    nextNeg();
    applyStimulus(0, 1'b1, 3'b010, 8'h10, 8'h20);
    applyStimulus(1, 1'b1, 3'b011, 8'h0F, 8'hF0);
    for (int i = 0; i < 4; i++) begin
      #1;
`ifdef ALU_ARB_RR_EN
      expG = i[0];
`else
      expG = 1'b0;
`endif
      checkOutput($sformatf("t2_grant%0d", i), {req1Ready, req0Ready}, expG ? 2'b10 : 2'b01);
      nextNeg();
      nextNeg();
      nextNeg();
      checkOutput($sformatf("t2_rsp%0d", i), {rsp1Valid, rsp0Valid}, expG ? 2'b10 : 2'b01);
      checkOutput($sformatf("t2_res%0d", i), result, expG ? 8'hFF : 8'h30);
      if (i == 3) begin
        applyStimulus(0, 1'b0, 3'b010, 8'h10, 8'h20);
        applyStimulus(1, 1'b0, 3'b011, 8'h0F, 8'hF0);
      end
      nextNeg();
    end
    checkOutput("t2_idle", busy, 0);

    // Backpressure on requester 1's response while requester 0 keeps asking.
    rsp1Ready = 1'b0;
    applyStimulus(1, 1'b1, 3'b100, 8'h5A, 8'h11);
    #1;
    checkOutput("t3_ready1", req1Ready, 1);
    nextNeg();
    applyStimulus(1, 1'b0, 3'b100, 8'h5A, 8'h11);
    applyStimulus(0, 1'b1, 3'b001, 8'hFF, 8'h0F);
    nextNeg();
    nextNeg();
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t3_rsp1_%0d", i), rsp1Valid, 1);
      checkOutput($sformatf("t3_rsp0_%0d", i), rsp0Valid, 0);
      checkOutput($sformatf("t3_res_%0d", i), result, 8'h5A);
      checkOutput($sformatf("t3_busy_%0d", i), busy, 1);
      checkOutput($sformatf("t3_noready0_%0d", i), req0Ready, 0);
      nextNeg();
    end
    rsp1Ready = 1'b1;
    nextNeg();
    checkOutput("t3_idle_busy", busy, 0);
    checkOutput("t3_idle_ready0", req0Ready, 1);
    applyStimulus(0, 1'b0, 3'b001, 8'hFF, 8'h0F);

    // Asynchronous reset during EXEC, then a fresh ADD that wraps.
    nextNeg();
    applyStimulus(0, 1'b1, 3'b010, 8'hFF, 8'h02);
    nextNeg();
    checkOutput("t4_exec_busy", busy, 1);
    checkOutput("t4_exec_d1", aluData1, 8'hFF);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("t4_rst_busy", busy, 0);
    checkOutput("t4_rst_result", result, 0);
    checkOutput("t4_rst_alu", {aluData1, aluData2, aluSelect}, 0);
    checkOutput("t4_rst_rsp", {rsp0Valid, rsp1Valid}, 0);
    checkOutput("t4_rst_ready0", req0Ready, 0);
    nextNeg();
    rstN = 1'b1;
    #1;
    checkOutput("t4_reissue_ready0", req0Ready, 1);
    nextNeg();
    applyStimulus(0, 1'b0, 3'b010, 8'hFF, 8'h02);
    nextNeg();
    nextNeg();
    checkOutput("t4_rsp0", rsp0Valid, 1);
    checkOutput("t4_add_wrap", result, 8'h01);
    nextNeg();
    checkOutput("t4_done_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequential front-end that shares one 8-bit ALU datapath (AND/OR/ADD/MOV units with `#1`–`#2` combinational delay) between two requesters. These are the instruction-issue path (requester 0) and an auxiliary engine (requester 1). The block arbitrates, registers operands, and drives the ALU for a full settle cycle. It then captures the result and returns it to the granted requester over a valid/ready handshake. It sits between the register-file/control side and the ALU instance in the CPU top level.

## Interface
- `WIDTH`, 8, operand/result width.
- `SEL_W`, 3, ALU function-select width.

- `CLK`  in  1  system clock, rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `REQ0_VALID`, `REQ1_VALID`  in  1  request present.
- `REQ0_READY`, `REQ1_READY`  out  1  request accepted this cycle.
- `REQ0_SEL`, `REQ1_SEL`  in  SEL_W  ALU function select.
- `REQ0_DATA1`, `REQ0_DATA2`, `REQ1_DATA1`, `REQ1_DATA2`  in  WIDTH  operands.
- `RSP0_VALID`, `RSP1_VALID`  out  1  result available for that requester.
- `RSP0_READY`, `RSP1_READY`  in  1  requester takes result.
- `RESULT`  out  WIDTH  registered result, shared by both response channels.
- `ALU_DATA1`, `ALU_DATA2`  out  WIDTH  registered operands to ALU.
- `ALU_SELECT`  out  SEL_W  registered select to ALU.
- `ALU_RESULT`  in  WIDTH  ALU combinational output.
- `BUSY`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, CAPT, RESP.
- **IDLE**
  - Arbitrate among valid requesters and assert `REQn_READY` for the winner, combinationally from state and valids.
  - On the clock edge, load `ALU_DATA1/2`/`ALU_SELECT` from the winner, record grant index `g`, and go to EXEC.
  - If no request is valid, stay in IDLE; all READY low.
- **EXEC**: ALU inputs held stable for one full cycle; unconditionally go to CAPT.
- **CAPT**: `RESULT <= ALU_RESULT`; go to RESP.
- **RESP**
  - `RSPg_VALID=1`; the other RSP_VALID stays 0.
  - Hold `RESULT` and `RSPg_VALID` until `RSPg_READY=1` at a clock edge, then go to IDLE.
  - `RSP_READY` of the non-granted requester is ignored.
- ALU operand/select registers hold their last value outside IDLE→EXEC loads; `RESULT` holds until the next CAPT.
- Arbitration is per Configuration. Requests arriving while BUSY wait: no queueing, and requesters must hold VALID and payload until READY.
- A requester may drop VALID before READY without penalty.
- Result width equals WIDTH. Carry/overflow is discarded by the ALU and not observed here.

## Timing
- Reset (`RESET`=0, asynchronous):
  - State goes to IDLE.
  - `RESULT`, `ALU_DATA1`, `ALU_DATA2`, `ALU_SELECT` are 0.
  - `RSP0/1_VALID`, `BUSY` are 0.
  - `REQ0/1_READY` are forced to 0 while reset is asserted.
  - Round-robin pointer favours requester 0.
- Reset mid-operation: the in-flight op is dropped with no response, and the requester must reissue.
- Acceptance at edge N: EXEC during N→N+1, CAPT during N+1→N+2, and `RSPg_VALID` high after edge N+2.
- With `RSPg_READY` already high, the response completes at edge N+3 and the next acceptance can occur at edge N+4.
- Peak throughput is one operation per 4 cycles.
- The clock period must exceed the worst ALU delay (2 ns); EXEC guarantees a full period of settle.
- Simultaneous `REQ0_VALID`/`REQ1_VALID` in IDLE: exactly one READY is asserted, per the arbitration rule.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration.
  - The requester not granted last has priority on a tie.
  - The pointer updates on each acceptance.
- `ALU_ARB_RR_EN` undefined: fixed priority, requester 0 always wins ties. Requester 1 can starve.

## Test plan
- Reset then single request: `REQ0` OR, SEL=3'b011, 8'hA5, 8'h0F. Required:
  - `REQ0_READY` for 1 cycle.
  - `RSP0_VALID` 3 edges after accept.
  - `RESULT`=8'hAF.
  - `RSP1_VALID` stays 0.
- Simultaneous requests, both held, `RSP_READY` tied high:
  - With `ALU_ARB_RR_EN`: grants alternate 0,1,0,1.
  - Without it: four consecutive grants go to 0 while `REQ0_VALID` is held.
- Response backpressure: hold `RSP1_READY`=0 for 5 cycles. Required:
  - `RSP1_VALID` and `RESULT` stable throughout.
  - `BUSY`=1.
  - No `REQ0_READY` despite `REQ0_VALID`.
  - IDLE one edge after `RSP1_READY` rises.
- Reset asserted asynchronously during EXEC:
  - Immediately `BUSY`=0, `RESULT`=0, `ALU_*`=0, no RSP_VALID.
  - After release, a fresh request completes normally.
- ADD wrap: 8'hFF + 8'h02 -> `RESULT`=8'h01.
- Operand stability: change `REQ0_DATA1` after accept -> `ALU_DATA1` unchanged until the next acceptance.
